// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
//
// MEM-stage data-memory access controller. Converts the EX/MEM control word
// into a req/ack transaction on a multi-cycle data memory, aligns store data
// and byte enables to the addressed lanes, stalls the pipeline while the
// access is in flight and returns sign/zero-extended load data to WB.
//
// Parameters
//   MAX_WAIT   : cycles DmemReq may stay high without DmemAck before abort
//   WAIT_W     : width of the wait counter (must hold MAX_WAIT)
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   AluOutM[31:0]       : byte address of the access
//   StoreDataM[31:0]    : store data, lane-0 justified
//   MemWriteM[3:0]      : store byte mask, lane-0 justified (0000 = no store)
//   MemToRegM           : instruction is a load
//   RegWriteM[2:0]      : load type (1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU)
//   DmemReq             : memory request, held until acknowledged
//   DmemWe[3:0]         : lane-shifted byte write enables (0000 = read)
//   DmemAddr[31:0]      : word-aligned address
//   DmemWData[31:0]     : lane-shifted store data
//   DmemAck             : memory completes the request this cycle
//   DmemRData[31:0]     : read word, valid with DmemAck
//   StallMem            : hold IF/ID/EX/MEM, bubble MEM/WB (combinational)
//   LoadDataW[31:0]     : extended load result, held until next load
//   LoadValidW          : one-cycle pulse, LoadDataW updated
//   MemErr              : one-cycle pulse, misaligned access or timeout
// ---------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] AluOutM,
    input  logic [31:0] StoreDataM,
    input  logic [3:0]  MemWriteM,
    input  logic        MemToRegM,
    input  logic [2:0]  RegWriteM,
    output logic        DmemReq,
    output logic [3:0]  DmemWe,
    output logic [31:0] DmemAddr,
    output logic [31:0] DmemWData,
    input  logic        DmemAck,
    input  logic [31:0] DmemRData,
    output logic        StallMem,
    output logic [31:0] LoadDataW,
    output logic        LoadValidW,
    output logic        MemErr
);

    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LBU = 3'd4;
    localparam logic [2:0] LT_LHU = 3'd5;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       ldata_q, ldata_d;
    logic              lvalid_q, lvalid_d;
    logic              err_q, err_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;
    // Attributes of the in-flight access, needed when the ack returns.
    logic              isload_q, isload_d;
    logic [2:0]        ltype_q, ltype_d;
    logic [1:0]        off_q, off_d;

    logic              pending;
    logic [1:0]        off;
    logic              stall;

    // Halfword accesses need an even address, word accesses (including loads
    // with an unrecognised type, which behave as LW) need offset 0.
    function automatic logic misaligned(input logic       is_ld,
                                        input logic [2:0] lt,
                                        input logic [3:0] mask,
                                        input logic [1:0] o);
        logic half;
        logic word;
        if (is_ld) begin
            half = (lt == LT_LH) || (lt == LT_LHU);
            word = !((lt == LT_LB) || (lt == LT_LBU) || half);
        end else begin
            half = (mask == 4'b0011);
            word = (mask == 4'b1111);
        end
        return (half && o[0]) || (word && (o != 2'b00));
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                                input logic [2:0]  lt,
                                                input logic [1:0]  o);
        logic [31:0] w;
        w = rdata >> {o, 3'b000};
        case (lt)
            LT_LB:   return {{24{w[7]}}, w[7:0]};
            LT_LBU:  return {24'h0, w[7:0]};
            LT_LH:   return {{16{w[15]}}, w[15:0]};
            LT_LHU:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign off     = AluOutM[1:0];
    assign pending = MemToRegM || (MemWriteM != 4'b0000);

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ldata_d  = ldata_q;
        lvalid_d = 1'b0;
        err_d    = 1'b0;
        wcnt_d   = wcnt_q;
        isload_d = isload_q;
        ltype_d  = ltype_q;
        off_d    = off_q;
        stall    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending) begin
                    stall = 1'b1;
                    if (misaligned(MemToRegM, RegWriteM, MemWriteM, off)) begin
                        // No memory traffic; report the error in DONE.
                        err_d    = 1'b1;
                        lvalid_d = MemToRegM;
                        if (MemToRegM) begin
                            ldata_d = 32'h0;
                        end
                        state_d = S_DONE;
                    end else begin
                        req_d    = 1'b1;
                        addr_d   = {AluOutM[31:2], 2'b00};
                        we_d     = MemWriteM << off;
                        wdata_d  = StoreDataM << {off, 3'b000};
                        wcnt_d   = '0;
                        isload_d = MemToRegM;
                        ltype_d  = RegWriteM;
                        off_d    = off;
                        state_d  = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                stall = 1'b1;
                if (DmemAck) begin
                    req_d    = 1'b0;
                    lvalid_d = isload_q;
                    if (isload_q) begin
                        ldata_d = extend_load(DmemRData, ltype_q, off_q);
                    end
                    state_d = S_DONE;
                end else if (wcnt_q == WAIT_LAST) begin
                    // Request has been up for MAX_WAIT cycles: abort.
                    req_d    = 1'b0;
                    err_d    = 1'b1;
                    lvalid_d = isload_q;
                    if (isload_q) begin
                        ldata_d = 32'h0;
                    end
                    state_d = S_DONE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end

            // Segment registers advance here; the inputs still show the
            // completed instruction, so they are deliberately not examined.
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 4'b0000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            ldata_q  <= 32'h0;
            lvalid_q <= 1'b0;
            err_q    <= 1'b0;
            wcnt_q   <= '0;
            isload_q <= 1'b0;
            ltype_q  <= 3'd0;
            off_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ldata_q  <= ldata_d;
            lvalid_q <= lvalid_d;
            err_q    <= err_d;
            wcnt_q   <= wcnt_d;
            isload_q <= isload_d;
            ltype_q  <= ltype_d;
            off_q    <= off_d;
        end
    end

    assign DmemReq    = req_q;
    assign DmemWe     = we_q;
    assign DmemAddr   = addr_q;
    assign DmemWData  = wdata_q;
    assign LoadDataW  = ldata_q;
    assign LoadValidW = lvalid_q;
    assign MemErr     = err_q;
    assign StallMem   = stall;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_ctrl
//
// Drives MEM-stage accesses transaction by transaction, acts as a data
// memory with a chosen ack delay, and compares the controller against a
// transaction-level reference: expected bus fields, stall length, request
// length, load result and error pulses are computed from the access rules.
// ---------------------------------------------------------------------------
module tb_mem_stage_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int WAIT_W   = 3;
    localparam int BOUND    = 3 * MAX_WAIT + 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] AluOutM;
    logic [31:0] StoreDataM;
    logic [3:0]  MemWriteM;
    logic        MemToRegM;
    logic [2:0]  RegWriteM;
    logic        DmemReq;
    logic [3:0]  DmemWe;
    logic [31:0] DmemAddr;
    logic [31:0] DmemWData;
    logic        DmemAck;
    logic [31:0] DmemRData;
    logic        StallMem;
    logic [31:0] LoadDataW;
    logic        LoadValidW;
    logic        MemErr;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] ldata_m = 32'h0;   // reference copy of the held load result

    mem_stage_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
        .clk(clk), .rst(rst),
        .AluOutM(AluOutM), .StoreDataM(StoreDataM), .MemWriteM(MemWriteM),
        .MemToRegM(MemToRegM), .RegWriteM(RegWriteM),
        .DmemReq(DmemReq), .DmemWe(DmemWe), .DmemAddr(DmemAddr),
        .DmemWData(DmemWData), .DmemAck(DmemAck), .DmemRData(DmemRData),
        .StallMem(StallMem), .LoadDataW(LoadDataW), .LoadValidW(LoadValidW),
        .MemErr(MemErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Access size in bytes as implied by the instruction.
    function automatic int acc_bytes(input logic ld, input logic [2:0] t, input logic [3:0] m);
        if (ld) return (t == 3'd1 || t == 3'd4) ? 1 : (t == 3'd2 || t == 3'd5) ? 2 : 4;
        return $countones(m);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [2:0] t);
        logic [31:0] w;
        int v;
        w = rd >> (8 * (a % 4));
        case (t)
            3'd1: begin v = int'(w % 256);   if (v >= 128)   v = v - 256;   return 32'(v); end
            3'd4: return w % 256;
            3'd2: begin v = int'(w % 65536); if (v >= 32768) v = v - 65536; return 32'(v); end
            3'd5: return w % 65536;
            default: return w;
        endcase
    endfunction

    task automatic idle_cycle();
        @(posedge clk); #1;
        MemToRegM = 1'b0; MemWriteM = 4'b0000;
        AluOutM = $urandom; StoreDataM = $urandom; RegWriteM = 3'($urandom);
        DmemAck = 1'($urandom); DmemRData = $urandom;
        @(negedge clk);
        chk("idle_stall", 32'(StallMem), 0);
        chk("idle_req", 32'(DmemReq), 0);
        chk("idle_lvalid", 32'(LoadValidW), 0);
        chk("idle_err", 32'(MemErr), 0);
        chk("idle_ldata", LoadDataW, ldata_m);
    endtask

    // One complete access; delay = BUSY cycles before ack (>= MAX_WAIT: none).
    task automatic run_access(input logic [31:0] a, input logic [31:0] sd, input logic [3:0] m,
                              input logic ld, input logic [2:0] t, input int delay,
                              input logic [31:0] rd);
        int  sz, stalls, reqs;
        bit  mis, tmo, done;
        logic [31:0] exp_ld;
        sz  = acc_bytes(ld, t, m);
        mis = (sz > 1) && ((a % sz) != 0);
        tmo = !mis && (delay >= MAX_WAIT);
        stalls = 0; reqs = 0; done = 0;
        for (int cyc = 0; cyc < BOUND && !done; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0) begin
                AluOutM = a; StoreDataM = sd; MemWriteM = ld ? 4'b0000 : m;
                MemToRegM = ld; RegWriteM = t;
            end
            if (DmemReq) begin
                DmemAck   = (reqs == delay);
                DmemRData = (reqs == delay) ? rd : $urandom;
                reqs++;
            end else begin
                DmemAck = 1'($urandom); DmemRData = $urandom;
            end
            @(negedge clk);
            if (DmemReq) begin
                chk("addr", DmemAddr, a - (a % 4));
                chk("we", 32'(DmemWe), ld ? 0 : 32'((m << (a % 4)) % 16));
                chk("wdata", DmemWData, sd << (8 * (a % 4)));
            end
            if (StallMem) stalls++;
            else done = 1;
        end
        if (!done) chk("stall_bound", 0, 1);
        chk("stall_len", 32'(stalls), mis ? 1 : tmo ? MAX_WAIT + 1 : delay + 2);
        chk("req_len", 32'(reqs), mis ? 0 : tmo ? MAX_WAIT : delay + 1);
        chk("done_req", 32'(DmemReq), 0);
        chk("done_lvalid", 32'(LoadValidW), 32'(ld));
        chk("done_err", 32'(MemErr), 32'(mis || tmo));
        if (ld) begin
            exp_ld  = (mis || tmo) ? 32'h0 : model_load(rd, a, t);
            ldata_m = exp_ld;
        end
        chk("done_ldata", LoadDataW, ldata_m);
    endtask

    initial begin
        rst = 1'b1; AluOutM = '0; StoreDataM = '0; MemWriteM = '0;
        MemToRegM = 1'b0; RegWriteM = '0; DmemAck = 1'b0; DmemRData = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(DmemReq), 0);
        chk("rst_we", 32'(DmemWe), 0);
        chk("rst_addr", DmemAddr, 0);
        chk("rst_wdata", DmemWData, 0);
        chk("rst_ldata", LoadDataW, 0);
        chk("rst_lvalid", 32'(LoadValidW), 0);
        chk("rst_err", 32'(MemErr), 0);
        chk("rst_stall", 32'(StallMem), 0);
        repeat (3) idle_cycle();

        // Directed cases
        run_access(32'h1003, 32'h000000AB, 4'b0001, 1'b0, 3'd0, 0, 32'h0);   // SB lane 3
        idle_cycle();
        run_access(32'h2002, 32'h0, 4'b0000, 1'b1, 3'd1, 2, 32'h12F45678);   // LB
        idle_cycle();
        run_access(32'h2002, 32'h0, 4'b0000, 1'b1, 3'd4, 2, 32'h12F45678);   // LBU
        run_access(32'h2002, 32'h0, 4'b0000, 1'b1, 3'd2, 2, 32'h12F45678);   // LH, back to back
        idle_cycle();
        run_access(32'h3001, 32'h0, 4'b0000, 1'b1, 3'd3, 0, 32'hDEADBEEF);   // misaligned LW
        idle_cycle();
        run_access(32'h2000, 32'h0, 4'b0000, 1'b1, 3'd3, 0, 32'hCAFEF00D);   // LW
        run_access(32'h4000, 32'h0, 4'b0000, 1'b1, 3'd3, 99, 32'h0);         // timeout load
        idle_cycle();
        run_access(32'h5006, 32'h1234BEEF, 4'b0011, 1'b0, 3'd0, 1, 32'h0);   // SH upper half
        run_access(32'h5000, 32'h8899AABB, 4'b1111, 1'b0, 3'd0, 99, 32'h0);  // SW timeout
        run_access(32'h6003, 32'h0, 4'b0000, 1'b1, 3'd5, 1, 32'hFFFF0000);   // misaligned LHU
        run_access(32'h6001, 32'h0, 4'b0000, 1'b1, 3'd7, 0, 32'h55667788);   // odd type -> LW rules
        run_access(32'h6004, 32'h0, 4'b0000, 1'b1, 3'd0, 3, 32'h80000001);   // odd type, aligned
        idle_cycle();

        // Randomized accesses
        for (int i = 0; i < 80; i++) begin
            logic        ld;
            logic [2:0]  t;
            logic [3:0]  m;
            int          k;
            ld = 1'($urandom);
            k  = $urandom_range(0, 9);
            t  = (k < 8) ? 3'(1 + $urandom_range(0, 4)) : 3'($urandom_range(6, 7));
            k  = $urandom_range(0, 2);
            m  = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0011 : 4'b1111;
            run_access($urandom, $urandom, m, ld, t, $urandom_range(0, 5), $urandom);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        // Reset during the second BUSY cycle, ack arriving one cycle late
        @(posedge clk); #1;
        AluOutM = 32'h7000; MemToRegM = 1'b1; RegWriteM = 3'd3; MemWriteM = 4'b0000;
        DmemAck = 1'b0;
        @(negedge clk); chk("rb_stall0", 32'(StallMem), 1);
        @(posedge clk); #1 DmemAck = 1'b0;
        @(negedge clk); chk("rb_busy1_req", 32'(DmemReq), 1);
        @(posedge clk); #1 DmemAck = 1'b0; rst = 1'b1;
        @(negedge clk); chk("rb_busy2_req", 32'(DmemReq), 1);
        @(posedge clk); #1;
        rst = 1'b0; MemToRegM = 1'b0; DmemAck = 1'b1; DmemRData = 32'h13572468;
        ldata_m = 32'h0;
        @(negedge clk);
        chk("rb_req", 32'(DmemReq), 0);
        chk("rb_stall", 32'(StallMem), 0);
        chk("rb_lvalid", 32'(LoadValidW), 0);
        chk("rb_err", 32'(MemErr), 0);
        chk("rb_ldata", LoadDataW, 0);
        idle_cycle();
        idle_cycle();
        run_access(32'h7004, 32'h0, 4'b0000, 1'b1, 3'd2, 0, 32'h0000A5A5);   // recovers after reset

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
